// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: ends the branch stall raised by the stall detector.
// Sees beq/bne/j in decode, stalls and flushes fetch, resolves the branch in
// execute, redirects the PC, drains, then releases stallFlag.
// Optional feature macro: BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_resolve_unit #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [5:0]  id_opcode,
  input  logic        ex_valid,
  input  logic [5:0]  ex_opcode,
  input  logic        ex_zero,
  input  logic [31:0] ex_pc_plus4,
  input  logic [31:0] ex_imm,
  input  logic [25:0] ex_jtarget,
  output logic        stallFlag,
  output logic        flush_f,
  output logic        flush_d,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        err_timeout
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_cnt,
  output logic [15:0] nt_cnt
`endif
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned PC_W  = 32;
  localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE = 6'b000101;
  localparam logic [OP_W-1:0] OP_J   = 6'b000010;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_EX, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall_q, stall_d;
  logic              flush_f_q, flush_f_d;
  logic              flush_d_q, flush_d_d;
  logic              rv_q, rv_d;
  logic [PC_W-1:0]   rpc_q, rpc_d;
  logic              err_q, err_d;
  logic              taken_inc_c, nt_inc_c;

  logic              id_is_br_c, ex_match_c, taken_c, idle_rules_c;
  logic [PC_W-1:0]   target_c;

  assign id_is_br_c = id_valid &&
                      (id_opcode == OP_BEQ || id_opcode == OP_BNE || id_opcode == OP_J);
  assign ex_match_c = ex_valid && (ex_opcode == op_q);

  // Taken decision and target for the captured opcode
  always_comb begin
    taken_c  = 1'b0;
    target_c = PC_W'(ex_pc_plus4 + PC_W'(ex_imm << 2));
    case (op_q)
      OP_BEQ:  taken_c = ex_zero;
      OP_BNE:  taken_c = !ex_zero;
      OP_J: begin
        taken_c  = 1'b1;
        target_c = {ex_pc_plus4[31:28], ex_jtarget, 2'b00};
      end
      default: taken_c = 1'b0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    stall_d      = stall_q;
    flush_f_d    = 1'b0;
    flush_d_d    = 1'b0;
    rv_d         = 1'b0;
    rpc_d        = rpc_q;
    err_d        = err_q;
    taken_inc_c  = 1'b0;
    nt_inc_c     = 1'b0;
    idle_rules_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_d      = 1'b1;
        idle_rules_c = 1'b1;
      end
      S_WAIT_EX: begin
        stall_d = 1'b0;
        if (ex_match_c) begin
          if (taken_c) begin
            rv_d        = 1'b1;
            flush_f_d   = 1'b1;
            flush_d_d   = 1'b1;
            rpc_d       = target_c;
            cnt_d       = '0;
            state_d     = S_DRAIN;
            taken_inc_c = 1'b1;
          end else begin
            stall_d  = 1'b1;
            state_d  = S_IDLE;
            nt_inc_c = 1'b1;
          end
        end else if (CNT_W'(cnt_q + 8'd1) == CNT_W'(TIMEOUT)) begin
          stall_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = CNT_W'(cnt_q + 8'd1);
        end
      end
      S_DRAIN: begin
        stall_d = 1'b0;
        if (cnt_q == CNT_W'(DRAIN_CYCLES)) begin
          stall_d      = 1'b1;
          state_d      = S_IDLE;
          idle_rules_c = 1'b1;
        end else begin
          cnt_d = CNT_W'(cnt_q + 8'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A decode branch seen under idle rules starts a new stall
    if (idle_rules_c && id_is_br_c) begin
      op_d      = id_opcode;
      cnt_d     = '0;
      stall_d   = 1'b0;
      flush_f_d = 1'b1;
      state_d   = S_WAIT_EX;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      stall_q   <= 1'b1;
      flush_f_q <= 1'b0;
      flush_d_q <= 1'b0;
      rv_q      <= 1'b0;
      rpc_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      flush_f_q <= flush_f_d;
      flush_d_q <= flush_d_d;
      rv_q      <= rv_d;
      rpc_q     <= rpc_d;
      err_q     <= err_d;
    end
  end

  assign stallFlag      = stall_q;
  assign flush_f        = flush_f_q;
  assign flush_d        = flush_d_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign err_timeout    = err_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_q, nt_q;

  // Saturating resolution counters; timeouts are not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q <= '0;
      nt_q    <= '0;
    end else begin
      if (taken_inc_c && taken_q != 16'hFFFF) taken_q <= 16'(taken_q + 16'd1);
      if (nt_inc_c && nt_q != 16'hFFFF)       nt_q    <= 16'(nt_q + 16'd1);
    end
  end

  assign taken_cnt = taken_q;
  assign nt_cnt    = nt_q;
`else
  logic unused_stats_c;
  assign unused_stats_c = taken_inc_c ^ nt_inc_c;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (DRAIN_CYCLES=2, TIMEOUT=8).
module tb_branch_resolve_unit;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ADD = 6'b000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [5:0]  id_opcode = '0;
  logic        ex_valid = 1'b0;
  logic [5:0]  ex_opcode = '0;
  logic        ex_zero = 1'b0;
  logic [31:0] ex_pc_plus4 = '0;
  logic [31:0] ex_imm = '0;
  logic [25:0] ex_jtarget = '0;
  logic        stallFlag, flush_f, flush_d, redirect_valid, err_timeout;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt, nt_cnt;
`endif

  int errors = 0;
  int checks = 0;

  branch_resolve_unit #(.DRAIN_CYCLES(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_zero(ex_zero),
    .ex_pc_plus4(ex_pc_plus4), .ex_imm(ex_imm), .ex_jtarget(ex_jtarget),
    .stallFlag(stallFlag), .flush_f(flush_f), .flush_d(flush_d),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .err_timeout(err_timeout)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .nt_cnt(nt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs then show the following cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (stallFlag !== 1'b1) begin errors++; $display("FAIL reset_stall got=%b exp=1", stallFlag); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got=%b exp=0", redirect_valid); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    checks++; if ({flush_f, flush_d} !== 2'b00) begin errors++; $display("FAIL reset_flush got=%b exp=00", {flush_f, flush_d}); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", redirect_pc); end
    rst = 1'b0;
  endtask

  task automatic test_beq_taken();
    id_valid = 1'b1; id_opcode = OP_BEQ;
    tick();  // edge N
    id_valid = 1'b0;
    checks++; if ({stallFlag, flush_f, redirect_valid} !== 3'b010) begin errors++; $display("FAIL beq_accept s/ff/rv got=%b exp=010", {stallFlag, flush_f, redirect_valid}); end
    tick();
    checks++; if ({stallFlag, flush_f} !== 2'b00) begin errors++; $display("FAIL beq_wait s/ff got=%b exp=00", {stallFlag, flush_f}); end
    ex_valid = 1'b1; ex_opcode = OP_BEQ; ex_zero = 1'b1; ex_pc_plus4 = 32'h100; ex_imm = 32'h4;
    tick();  // edge M
    ex_valid = 1'b0;
    checks++; if ({redirect_valid, flush_d, flush_f, stallFlag} !== 4'b1110) begin errors++; $display("FAIL beq_redirect rv/fd/ff/s got=%b exp=1110", {redirect_valid, flush_d, flush_f, stallFlag}); end
    checks++; if (redirect_pc !== 32'h110) begin errors++; $display("FAIL beq_target got=%h exp=00000110", redirect_pc); end
    tick();
    checks++; if ({redirect_valid, stallFlag} !== 2'b00) begin errors++; $display("FAIL beq_drain1 rv/s got=%b exp=00", {redirect_valid, stallFlag}); end
    checks++; if (redirect_pc !== 32'h110) begin errors++; $display("FAIL beq_pc_hold got=%h exp=00000110", redirect_pc); end
    tick();
    checks++; if (stallFlag !== 1'b0) begin errors++; $display("FAIL beq_drain2 got=%b exp=0", stallFlag); end
    tick();
    checks++; if (stallFlag !== 1'b1) begin errors++; $display("FAIL beq_release got=%b exp=1", stallFlag); end
  endtask

  task automatic test_bne_not_taken();
    id_valid = 1'b1; id_opcode = OP_BNE;
    tick();
    id_valid = 1'b0;
    checks++; if (stallFlag !== 1'b0) begin errors++; $display("FAIL bne_accept got=%b exp=0", stallFlag); end
    ex_valid = 1'b1; ex_opcode = OP_BNE; ex_zero = 1'b1; ex_pc_plus4 = 32'h200; ex_imm = 32'h8;
    tick();
    ex_valid = 1'b0;
    checks++; if ({stallFlag, redirect_valid, flush_d} !== 3'b100) begin errors++; $display("FAIL bne_nt s/rv/fd got=%b exp=100", {stallFlag, redirect_valid, flush_d}); end
    checks++; if (redirect_pc !== 32'h110) begin errors++; $display("FAIL bne_pc_hold got=%h exp=00000110", redirect_pc); end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    checks++; if ({taken_cnt, nt_cnt} !== {16'd1, 16'd1}) begin errors++; $display("FAIL stats taken/nt got=%0d/%0d exp=1/1", taken_cnt, nt_cnt); end
  endtask
`endif

  task automatic test_jump_wrap();
    id_valid = 1'b1; id_opcode = OP_J;
    tick();
    id_valid = 1'b0;
    ex_valid = 1'b1; ex_opcode = OP_J; ex_pc_plus4 = 32'hF000_0004; ex_jtarget = 26'h3FF_FFFF;
    tick();
    ex_valid = 1'b0;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL j_rv got=%b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL j_target got=%h exp=fffffffc", redirect_pc); end
    tick();
    tick();
  endtask

  // Branch arriving on the DRAIN exit edge is accepted; bne taken follows
  task automatic test_back_to_back();
    id_valid = 1'b1; id_opcode = OP_BNE;
    tick();  // DRAIN exit edge
    id_valid = 1'b0;
    checks++; if ({stallFlag, flush_f} !== 2'b01) begin errors++; $display("FAIL b2b_accept s/ff got=%b exp=01", {stallFlag, flush_f}); end
    ex_valid = 1'b1; ex_opcode = OP_BNE; ex_zero = 1'b0; ex_pc_plus4 = 32'h1000; ex_imm = 32'h10;
    tick();
    ex_valid = 1'b0;
    checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h1040}) begin errors++; $display("FAIL b2b_bne_taken rv/pc got=%b/%h exp=1/00001040", redirect_valid, redirect_pc); end
    tick(); tick(); tick();
    checks++; if (stallFlag !== 1'b1) begin errors++; $display("FAIL b2b_release got=%b exp=1", stallFlag); end
  endtask

  task automatic test_beq_wrap();
    id_valid = 1'b1; id_opcode = OP_BEQ;
    tick();
    id_valid = 1'b0;
    ex_valid = 1'b1; ex_opcode = OP_ADD; ex_zero = 1'b1; ex_pc_plus4 = 32'h0; ex_imm = 32'hFFFF_FFFF;
    tick();
    checks++; if ({redirect_valid, stallFlag} !== 2'b00) begin errors++; $display("FAIL wrap_nomatch rv/s got=%b exp=00", {redirect_valid, stallFlag}); end
    ex_opcode = OP_BEQ;
    tick();
    ex_valid = 1'b0;
    checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'hFFFF_FFFC}) begin errors++; $display("FAIL beq_wrap rv/pc got=%b/%h exp=1/fffffffc", redirect_valid, redirect_pc); end
    tick(); tick(); tick();
  endtask

  task automatic test_timeout();
    id_valid = 1'b1; id_opcode = OP_J;
    tick();  // edge N
    id_opcode = OP_BEQ;  // decode branch during WAIT_EX must be ignored
    for (int i = 0; i < 7; i++) tick();
    id_valid = 1'b0;
    checks++; if ({stallFlag, err_timeout, flush_f} !== 3'b000) begin errors++; $display("FAIL to_before s/err/ff got=%b exp=000", {stallFlag, err_timeout, flush_f}); end
    tick();  // edge N+8
    checks++; if ({stallFlag, err_timeout, redirect_valid} !== 3'b110) begin errors++; $display("FAIL to_fire s/err/rv got=%b exp=110", {stallFlag, err_timeout, redirect_valid}); end
    tick(); tick();
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", err_timeout); end
  endtask

  // Match on the same edge as the timeout wins
  task automatic test_timeout_tie();
    id_valid = 1'b1; id_opcode = OP_BEQ;
    tick();
    id_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    ex_valid = 1'b1; ex_opcode = OP_BEQ; ex_zero = 1'b1; ex_pc_plus4 = 32'h300; ex_imm = 32'h1;
    tick();
    ex_valid = 1'b0;
    checks++; if ({redirect_valid, stallFlag, redirect_pc} !== {2'b10, 32'h304}) begin errors++; $display("FAIL tie rv/s/pc got=%b%b/%h exp=10/00000304", redirect_valid, stallFlag, redirect_pc); end
  endtask

  // Reset while draining, and reset on the resolving edge drops the redirect
  task automatic test_reset_mid_drain();
    tick();  // now in DRAIN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({stallFlag, err_timeout, redirect_valid, flush_f, flush_d} !== 5'b10000) begin errors++; $display("FAIL rst_drain s/err/rv/ff/fd got=%b exp=10000", {stallFlag, err_timeout, redirect_valid, flush_f, flush_d}); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_drain_pc got=%h exp=0", redirect_pc); end
    id_valid = 1'b1; id_opcode = OP_J;
    tick();
    id_valid = 1'b0;
    ex_valid = 1'b1; ex_opcode = OP_J; ex_pc_plus4 = 32'h1000_0000; ex_jtarget = 26'h10;
    rst = 1'b1;
    tick();
    rst = 1'b0; ex_valid = 1'b0;
    checks++; if ({redirect_valid, stallFlag, redirect_pc} !== {2'b01, 32'h0}) begin errors++; $display("FAIL rst_inflight rv/s/pc got=%b%b/%h exp=01/00000000", redirect_valid, stallFlag, redirect_pc); end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    test_jump_wrap();
    test_back_to_back();
    test_beq_wrap();
    test_timeout();
    test_timeout_tie();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
